// File: rtl/sync_fifo_ctrl.sv
// Single-clock circular FIFO controller with level/threshold flags, sticky
// overflow/underflow errors, synchronous flush and selectable show-ahead read.
module sync_fifo_ctrl #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned FWFT      = 0,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic                       clk_sys_i,
   input  logic                       rst_sys_i,
   input  logic                       flush_i,
   input  logic                       write_enable_i,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       read_enable_i,
   output logic [WIDTH-1:0]           data_out,
   output logic                       rx_ack_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       almost_full_o,
   output logic                       almost_empty_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   output logic                       underflow_o,
   input  logic                       err_clr_i
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_LVL    = LW'(AE_THRESH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_active;
   logic             w_pop_ok;
   logic             w_push_ok;
   logic             w_ovf_set;
   logic             w_unf_set;

   // Flags decode straight from the level register
   assign empty_o        = (r_level == '0);
   assign full_o         = (r_level == DEPTH_LVL);
   assign almost_full_o  = (r_level >= AF_LVL);
   assign almost_empty_o = (r_level <= AE_LVL);
   assign level_o        = r_level;
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

   // Reset and flush cycles neither move data nor raise errors
   assign w_active  = !rst_sys_i && !flush_i;
   assign w_pop_ok  = w_active && read_enable_i && !empty_o;
   assign w_push_ok = w_active && write_enable_i && (!full_o || w_pop_ok);
   assign w_ovf_set = w_active && write_enable_i && !w_push_ok;
   assign w_unf_set = w_active && read_enable_i && empty_o;

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky errors: a new event wins over a clear in the same cycle
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (err_clr_i) r_overflow <= 1'b0;
         if (w_unf_set)      r_underflow <= 1'b1;
         else if (err_clr_i) r_underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= data_in;
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [WIDTH-1:0] r_data_out;
         logic             r_rx_ack;

         always_ff @(posedge clk_sys_i) begin
            if (rst_sys_i) begin
               r_data_out <= '0;
               r_rx_ack   <= 1'b0;
            end else begin
               r_rx_ack <= w_pop_ok;
               if (w_pop_ok) r_data_out <= r_mem[r_rd_ptr];
            end
         end

         assign data_out = r_data_out;
         assign rx_ack_o = r_rx_ack;
      end else begin : g_show_ahead
         assign data_out = r_mem[r_rd_ptr];
         assign rx_ack_o = w_pop_ok;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Drives a registered-read and a show-ahead FIFO with identical stimulus and
// checks both against a queue-based reference model every cycle.
module tb_sync_fifo_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, fl, we, re, ec;
   logic [7:0] din;

   logic [7:0] dout0, dout1;
   logic       ack0, ack1, emp0, emp1, full0, full1, af0, af1, ae0, ae1;
   logic [2:0] lvl0, lvl1;
   logic       ovf0, ovf1, unf0, unf1;

   sync_fifo_ctrl #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_dut_reg (
      .clk_sys_i(clk), .rst_sys_i(rst), .flush_i(fl),
      .write_enable_i(we), .data_in(din), .read_enable_i(re),
      .data_out(dout0), .rx_ack_o(ack0), .empty_o(emp0), .full_o(full0),
      .almost_full_o(af0), .almost_empty_o(ae0), .level_o(lvl0),
      .overflow_o(ovf0), .underflow_o(unf0), .err_clr_i(ec)
   );

   sync_fifo_ctrl #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_dut_fwft (
      .clk_sys_i(clk), .rst_sys_i(rst), .flush_i(fl),
      .write_enable_i(we), .data_in(din), .read_enable_i(re),
      .data_out(dout1), .rx_ack_o(ack1), .empty_o(emp1), .full_o(full1),
      .almost_full_o(af1), .almost_empty_o(ae1), .level_o(lvl1),
      .overflow_o(ovf1), .underflow_o(unf1), .err_clr_i(ec)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as a queue plus the observable registers
   logic [7:0] m_q[$];
   logic       m_ovf = 1'b0, m_unf = 1'b0, m_ack0 = 1'b0, m_valid = 1'b0;
   logic [7:0] m_dout0 = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic i_rst, input logic i_fl, input logic i_we,
                       input logic [7:0] i_d, input logic i_re, input logic i_ec);
      int   n;
      logic pop, push;
      @(negedge clk);
      rst = i_rst; fl = i_fl; we = i_we; din = i_d; re = i_re; ec = i_ec;
      #1;
      n    = m_q.size();
      pop  = !i_rst && !i_fl && i_re && (n > 0);
      push = !i_rst && !i_fl && i_we && ((n < 4) || pop);
      if (m_valid) begin
         chk("level0", 32'(lvl0), 32'(n));
         chk("empty0", 32'(emp0), 32'(n == 0));
         chk("full0",  32'(full0), 32'(n == 4));
         chk("afull0", 32'(af0), 32'(n >= 2));
         chk("aempty0", 32'(ae0), 32'(n <= 2));
         chk("ovf0", 32'(ovf0), 32'(m_ovf));
         chk("unf0", 32'(unf0), 32'(m_unf));
         chk("dout0", 32'(dout0), 32'(m_dout0));
         chk("ack0", 32'(ack0), 32'(m_ack0));
         chk("level1", 32'(lvl1), 32'(n));
         chk("empty1", 32'(emp1), 32'(n == 0));
         chk("full1",  32'(full1), 32'(n == 4));
         chk("ovf1", 32'(ovf1), 32'(m_ovf));
         chk("unf1", 32'(unf1), 32'(m_unf));
         chk("ack1", 32'(ack1), 32'(pop));
         if (n > 0) chk("dout1", 32'(dout1), 32'(m_q[0]));
      end
      if (i_rst) begin
         m_q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_dout0 = 8'h00; m_ack0 = 1'b0;
         m_valid = 1'b1;
      end else if (i_fl) begin
         m_q.delete();
         m_ack0 = 1'b0;
         if (i_ec) begin m_ovf = 1'b0; m_unf = 1'b0; end
      end else begin
         m_ack0 = pop;
         if (pop)  m_dout0 = m_q.pop_front();
         if (push) m_q.push_back(i_d);
         if (i_we && !push) m_ovf = 1'b1;
         else if (i_ec)     m_ovf = 1'b0;
         if (i_re && n == 0) m_unf = 1'b1;
         else if (i_ec)      m_unf = 1'b0;
      end
      @(posedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      step(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic clr();
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b0; fl = 1'b0; we = 1'b0; re = 1'b0; ec = 1'b0; din = 8'h00;

      // Reset and fill
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      chk("rst_level", 32'(lvl0), 32'd0);
      chk("rst_empty", 32'(emp0), 32'd1);
      chk("rst_afull", 32'(af0), 32'd0);
      chk("rst_dout", 32'(dout0), 32'h0);
      push(8'hA0);
      push(8'hA1);
      #1 chk("lit_af_at2", 32'(af0), 32'd1);
      push(8'hA2);
      push(8'hA3);
      #1 chk("lit_full", 32'(full0), 32'd1);
      push(8'hA4);
      #1;
      chk("lit_ovf", 32'(ovf0), 32'd1);
      chk("lit_ovf_level", 32'(lvl0), 32'd4);
      clr();

      // Drain with interleaved pushes, wrapping both pointers
      pop();
      #1;
      chk("lit_dout_a0", 32'(dout0), 32'hA0);
      chk("lit_ack_a0", 32'(ack0), 32'd1);
      chk("lit_fwft_a1", 32'(dout1), 32'hA1);
      push(8'hB0); pop(); push(8'hB1); pop(); push(8'hB2); pop();
      push(8'hB3); pop(); push(8'hB4); pop(); push(8'hB5);
      pop(); pop(); pop(); pop();
      #1 chk("lit_dout_b5", 32'(dout0), 32'hB5);
      pop();
      #1 chk("lit_unf", 32'(unf0), 32'd1);
      clr();

      // Simultaneous push+pop at full
      push(8'h11); push(8'h12); push(8'h13); push(8'h14);
      step(1'b0, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b0);
      #1;
      chk("lit_full_pp_level", 32'(lvl0), 32'd4);
      chk("lit_full_pp_ovf", 32'(ovf0), 32'd0);
      chk("lit_full_pp_dout", 32'(dout0), 32'h11);
      pop(); pop(); pop(); pop();
      #1 chk("lit_c0_last", 32'(dout0), 32'hC0);

      // Simultaneous push+pop at empty
      step(1'b0, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b0);
      #1;
      chk("lit_empty_pp_unf", 32'(unf0), 32'd1);
      chk("lit_empty_pp_level", 32'(lvl0), 32'd1);
      chk("lit_empty_pp_ack", 32'(ack0), 32'd0);
      chk("lit_fwft_d0", 32'(dout1), 32'hD0);
      pop();
      #1 chk("lit_fwft_level0", 32'(lvl1), 32'd0);
      clr();

      // Show-ahead: word visible right after the push edge
      push(8'hE0);
      #1;
      chk("lit_fwft_e0", 32'(dout1), 32'hE0);
      chk("lit_fwft_nempty", 32'(emp1), 32'd0);
      pop();

      // Flush keeps sticky errors and registered read data
      push(8'h21); push(8'h22); push(8'h23); push(8'h24); push(8'h25);
      pop();
      step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      #1;
      chk("lit_flush_level", 32'(lvl0), 32'd0);
      chk("lit_flush_empty", 32'(emp0), 32'd1);
      chk("lit_flush_ovf", 32'(ovf0), 32'd1);
      chk("lit_flush_dout", 32'(dout0), 32'h21);
      clr();
      #1 chk("lit_clr_ovf", 32'(ovf0), 32'd0);
      push(8'h31); push(8'h32); pop(); push(8'h33);
      step(1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
      #1;
      chk("lit_rst_flush_level", 32'(lvl0), 32'd0);
      chk("lit_rst_flush_dout", 32'(dout0), 32'h0);
      chk("lit_rst_flush_ack", 32'(ack0), 32'd0);

      // Randomised traffic alternating between fill-biased and drain-biased phases
      for (int i = 0; i < 3000; i++) begin
         logic    r_we, r_re, r_fl, r_ec, r_rst;
         int unsigned hi;
         hi    = ((i / 150) % 2 == 0) ? 75 : 25;
         r_we  = ($urandom_range(0, 99) < hi);
         r_re  = ($urandom_range(0, 99) < (100 - hi));
         r_fl  = ($urandom_range(0, 39) == 0);
         r_ec  = !r_fl && ($urandom_range(0, 15) == 0);
         r_rst = ($urandom_range(0, 199) == 0);
         step(r_rst, r_fl, r_we, 8'($urandom), r_re, r_ec);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
